// File: rtl/transfer_pkg.sv
// rtl/transfer_pkg.sv - shared types, size encodings and opcodes for the load/store unit
//
// Purpose: common declarations imported by data_transfer_seq, load_align and the bench.
// Contents: state_e (sequencer states), SZ_* access-size encodings, OP_LW/OP_SW opcodes,
//           align_mask() and be_run() helpers.

package transfer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    localparam logic [1:0] SZ_BYTE   = 2'b00;
    localparam logic [1:0] SZ_HALF   = 2'b01;
    localparam logic [1:0] SZ_WORD   = 2'b10;
    localparam logic [1:0] SZ_DOUBLE = 2'b11;

    localparam logic [5:0] OP_LW = 6'd8;
    localparam logic [5:0] OP_SW = 6'd9;

    // Low address bits that must be zero for an access of the given size.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        return 3'((4'd1 << size) - 4'd1);
    endfunction

    // Right-aligned run of byte enables, one bit per byte of the access.
    function automatic logic [7:0] be_run(input logic [1:0] size);
        logic [7:0] run;
        case (size)
            SZ_BYTE: run = 8'h01;
            SZ_HALF: run = 8'h03;
            SZ_WORD: run = 8'h0F;
            default: run = 8'hFF;
        endcase
        return run;
    endfunction

endpackage

// File: rtl/data_transfer_seq_if.sv
// rtl/data_transfer_seq_if.sv - data memory request/grant/response bus
//
// Purpose: groups the data-memory port of data_transfer_seq.
// Signals: mem_req/mem_we/mem_addr/mem_be/mem_wdata (request, from the unit),
//          mem_gnt (request accepted), mem_rvalid/mem_rdata (load response, to the unit).
// Modports: master = load/store unit side, slave = memory side.

interface data_transfer_seq_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W/8-1:0]   mem_be;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [DATA_W-1:0]     mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );

endinterface

// File: rtl/load_align.sv
// rtl/load_align.sv - combinational load lane extraction and sign/zero extension
//
// Purpose: picks the (8<<size)-bit field at byte offset lane out of a memory word and
//          extends it to DATA_W bits.
// Ports: mem_rdata (memory word), lane (byte offset), size (access size),
//        sign_ext (1 = sign-extend), result (extended value).

module load_align
    import transfer_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int LANE_W = $clog2(DATA_W/8)
) (
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [LANE_W-1:0] lane,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic [DATA_W-1:0] result
);

    logic [DATA_W-1:0] shifted;
    logic [DATA_W-1:0] mask;
    logic              sign_bit;

    // Shift the addressed lane down to bit 0, keep only the access width, then fill
    // the upper bits with the field's top bit when sign extension is requested.
    always_comb begin
        shifted  = mem_rdata >> {lane, 3'b000};
        mask     = '1;
        sign_bit = 1'b0;
        case (size)
            SZ_BYTE: begin
                mask     = DATA_W'(8'hFF);
                sign_bit = shifted[7];
            end
            SZ_HALF: begin
                mask     = DATA_W'(16'hFFFF);
                sign_bit = shifted[15];
            end
            SZ_WORD: begin
                mask     = DATA_W'(32'hFFFF_FFFF);
                sign_bit = shifted[31];
            end
            default: begin
                mask     = '1;
                sign_bit = 1'b0;
            end
        endcase
        result = (shifted & mask) | ((sign_ext && sign_bit) ? ~mask : '0);
    end

endmodule

// File: rtl/data_transfer_seq.sv
// rtl/data_transfer_seq.sv - multi-cycle load/store sequencer with alignment check and timeout
//
// Purpose: computes ea = base + offset, rejects misaligned accesses, drives one memory
//          request per access and returns the extended load result.
// Ports: clk, rst (sync active-high); start/op_store/size/sign_ext/base/offset/wdata
//        (access request); busy/done/rdata/err_align/err_timeout (status and result);
//        mem (data memory bus, master side).

module data_transfer_seq
    import transfer_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              op_store,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    input  logic [DATA_W-1:0] base,
    input  logic [DATA_W-1:0] offset,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              err_align,
    output logic              err_timeout,
    data_transfer_seq_if.master mem
);

    localparam int BE_W   = DATA_W / 8;
    localparam int LANE_W = $clog2(BE_W);

    state_e              state;
    state_e              state_next;

    logic [ADDR_W-1:0]   ea;
    logic [LANE_W-1:0]   lane_in;
    logic                misaligned;
    logic [BE_W-1:0]     be_in;
    logic [DATA_W-1:0]   wdata_rep;

    logic                op_store_q;
    logic [1:0]          size_q;
    logic                sign_ext_q;
    logic [LANE_W-1:0]   lane_q;
    logic [7:0]          cnt;
    logic                timeout_hit;
    logic                abort;
    logic                err_align_q;
    logic                err_timeout_q;
    logic [DATA_W-1:0]   load_result;

    assign ea      = ADDR_W'(base + offset);
    assign lane_in = ea[LANE_W-1:0];

    // A double access cannot be honoured on a 32-bit port, so it is always rejected.
    assign misaligned = ((ea[2:0] & align_mask(size)) != 3'b000) ||
                        ((size == SZ_DOUBLE) && (DATA_W == 32));

    assign be_in = BE_W'(be_run(size)) << lane_in;

    always_comb begin
        wdata_rep = wdata;
        case (size)
            SZ_BYTE: wdata_rep = {BE_W{wdata[7:0]}};
            SZ_HALF: wdata_rep = {(BE_W/2){wdata[15:0]}};
            SZ_WORD: wdata_rep = {(BE_W/4){wdata[31:0]}};
            default: wdata_rep = wdata;
        endcase
    end

    load_align #(
        .DATA_W (DATA_W),
        .LANE_W (LANE_W)
    ) u_load_align (
        .mem_rdata (mem.mem_rdata),
        .lane      (lane_q),
        .size      (size_q),
        .sign_ext  (sign_ext_q),
        .result    (load_result)
    );

    // cnt holds the number of REQ/WAIT cycles already completed, so cnt+1 is the
    // ordinal of the current one; the abort fires in the first cycle at or past
    // TIMEOUT that lacks the event being waited for.
    assign timeout_hit = (({1'b0, cnt} + 9'd1) >= 9'(TIMEOUT));

    always_comb begin
        state_next = state;
        abort      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = misaligned ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (mem.mem_gnt) begin
                    state_next = op_store_q ? S_DONE : S_WAIT;
                end else if (timeout_hit) begin
                    state_next = S_DONE;
                    abort      = 1'b1;
                end
            end
            S_WAIT: begin
                if (mem.mem_rvalid) begin
                    state_next = S_DONE;
                end else if (timeout_hit) begin
                    state_next = S_DONE;
                    abort      = 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            op_store_q     <= 1'b0;
            size_q         <= 2'b00;
            sign_ext_q     <= 1'b0;
            lane_q         <= '0;
            cnt            <= 8'd0;
            err_align_q    <= 1'b0;
            err_timeout_q  <= 1'b0;
            rdata          <= '0;
            mem.mem_req    <= 1'b0;
            mem.mem_we     <= 1'b0;
            mem.mem_addr   <= '0;
            mem.mem_be     <= '0;
            mem.mem_wdata  <= '0;
        end else begin
            state       <= state_next;
            // Request is a register so it drops on the same edge the grant is taken.
            mem.mem_req <= (state_next == S_REQ);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_store_q    <= op_store;
                        size_q        <= size;
                        sign_ext_q    <= sign_ext;
                        lane_q        <= lane_in;
                        cnt           <= 8'd0;
                        err_align_q   <= misaligned;
                        err_timeout_q <= 1'b0;
                        mem.mem_we    <= op_store;
                        mem.mem_addr  <= ea & ~ADDR_W'(BE_W - 1);
                        mem.mem_be    <= be_in;
                        mem.mem_wdata <= wdata_rep;
                    end
                end
                S_REQ: begin
                    cnt <= cnt + 8'd1;
                    if (abort) begin
                        err_timeout_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (mem.mem_rvalid) begin
                        rdata <= load_result;
                    end else if (abort) begin
                        err_timeout_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy        = (state != S_IDLE);
    assign done        = (state == S_DONE);
    assign err_align   = done & err_align_q;
    assign err_timeout = done & err_timeout_q;

endmodule
